// File: rtl/mips_cpu_regfile_pkg.sv
// Package: mips_cpu_regfile_pkg
// Purpose: shared constants and types for the pipelined MIPS register file
//          and its pending-load scoreboard.
//   REG_ZERO   architectural zero register (hardwired to 0)
//   REG_V0     return-value register exported as register_v0
//   reg_addr_t register address at the default 5-bit address width
//   reg_data_t register word at the default 32-bit data width
package mips_cpu_regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam int REG_ZERO = 0;
  localparam int REG_V0   = 2;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/mips_cpu_regfile_sb_if.sv
// Interface: mips_cpu_regfile_sb_if
// Purpose: bundles the write, scoreboard and read signals of the register file.
//   master : drives wr_en/wr_addr/wr_data, pend_set/pend_addr, rd_addr;
//            receives rd_data, rd_busy, pend_count, register_v0
//   slave  : the register file side (mirror of master)
// rd_addr / rd_data are packed per port: port k at [k*W +: W].
interface mips_cpu_regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int N_RD   = 2
);
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     pend_set;
  logic [ADDR_W-1:0]        pend_addr;
  logic [N_RD*ADDR_W-1:0]   rd_addr;
  logic [N_RD*DATA_W-1:0]   rd_data;
  logic [N_RD-1:0]          rd_busy;
  logic [ADDR_W:0]          pend_count;
  logic [DATA_W-1:0]        register_v0;

  modport master (
    output wr_en, wr_addr, wr_data, pend_set, pend_addr, rd_addr,
    input  rd_data, rd_busy, pend_count, register_v0
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, pend_set, pend_addr, rd_addr,
    output rd_data, rd_busy, pend_count, register_v0
  );
endinterface

// File: rtl/mips_cpu_scoreboard.sv
// Module: mips_cpu_scoreboard
// Purpose: pending-load scoreboard. One bit per register marks a load whose
//          result has not yet been written back; decode uses rd_busy to stall.
// Ports:
//   clk          core clock
//   reset_n      asynchronous active-low reset, drops all pending marks
//   i_pend_set   load issued, mark i_pend_addr pending
//   i_pend_addr  destination of the issued load
//   i_wr_en      writeback strobe, clears the pending mark of i_wr_addr
//   i_wr_addr    writeback address
//   i_rd_addr    packed read addresses, one per read port
//   o_rd_busy    per read port: addressed register has a load outstanding
//   o_pend_count number of registers currently pending
module mips_cpu_scoreboard
  import mips_cpu_regfile_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int N_RD   = 2,
  parameter int BYPASS = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_pend_set,
  input  logic [ADDR_W-1:0]      i_pend_addr,
  input  logic                   i_wr_en,
  input  logic [ADDR_W-1:0]      i_wr_addr,
  input  logic [N_RD*ADDR_W-1:0] i_rd_addr,
  output logic [N_RD-1:0]        o_rd_busy,
  output logic [ADDR_W:0]        o_pend_count
);

  localparam int             DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

  logic [DEPTH-1:0] r_pending;
  logic [ADDR_W:0]  r_pend_count;

  logic w_set_hit;
  logic w_clr_hit;
  logic w_newly_set;
  logic w_cleared;

  assign w_set_hit   = i_pend_set && (i_pend_addr != ADDR_W'(REG_ZERO));
  assign w_clr_hit   = i_wr_en && (i_wr_addr != ADDR_W'(REG_ZERO));
  assign w_newly_set = w_set_hit && !r_pending[i_pend_addr];
  // A write to the register a new load targets in the same cycle does not
  // clear it: the newer load's result is still outstanding.
  assign w_cleared   = w_clr_hit && r_pending[i_wr_addr] &&
                       !(w_set_hit && (i_pend_addr == i_wr_addr));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending    <= '0;
      r_pend_count <= '0;
    end else begin
      if (w_clr_hit) r_pending[i_wr_addr] <= 1'b0;
      // Set is applied after clear so it wins on an address collision.
      if (w_set_hit) r_pending[i_pend_addr] <= 1'b1;
      // Count tracks the population of r_pending incrementally; it can never
      // exceed DEPTH-1 because register 0 is never marked.
      case ({w_newly_set, w_cleared})
        2'b10:   r_pend_count <= r_pend_count + CNT_ONE;
        2'b01:   r_pend_count <= r_pend_count - CNT_ONE;
        default: r_pend_count <= r_pend_count;
      endcase
    end
  end

  assign o_pend_count = r_pend_count;

  genvar gi;
  generate
    for (gi = 0; gi < N_RD; gi++) begin : g_busy
      logic [ADDR_W-1:0] w_addr;
      logic              w_masked;
      assign w_addr   = i_rd_addr[gi*ADDR_W +: ADDR_W];
      // With bypass the reader already gets the writeback data this cycle.
      assign w_masked = (BYPASS != 0) && w_clr_hit && (i_wr_addr == w_addr);
      assign o_rd_busy[gi] = (w_addr != ADDR_W'(REG_ZERO)) &&
                             r_pending[w_addr] && !w_masked;
    end
  endgenerate

endmodule

// File: rtl/mips_cpu_regfile_sb.sv
// Module: mips_cpu_regfile_sb
// Purpose: parametrised register file for the pipelined MIPS core with N_RD
//          combinational read ports, optional write->read bypass, per-register
//          valid bits (so reset clears architectural state without touching
//          the array) and a pending-load scoreboard.
// Ports:
//   clk      core clock, all state updates on the rising edge
//   reset_n  asynchronous active-low reset
//   bus      slave side of mips_cpu_regfile_sb_if (write, pend, read ports,
//            rd_data, rd_busy, pend_count, register_v0)
module mips_cpu_regfile_sb
  import mips_cpu_regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int N_RD   = 2,
  parameter int BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mips_cpu_regfile_sb_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_valid;

  logic w_wr_hit;

  // Writes to register 0 are dropped entirely; no write happens while the
  // core is held in reset.
  assign w_wr_hit = reset_n && bus.wr_en && (bus.wr_addr != ADDR_W'(REG_ZERO));

  // Storage array: no reset, contents survive reset and are masked by r_valid.
  always_ff @(posedge clk) begin
    if (w_wr_hit) r_mem[bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
    end else if (w_wr_hit) begin
      r_valid[bus.wr_addr] <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic              w_fwd;
      assign w_addr = bus.rd_addr[gi*ADDR_W +: ADDR_W];
      assign w_fwd  = (BYPASS != 0) && w_wr_hit && (bus.wr_addr == w_addr);
      // reset_n gates the bypass path too, so all ports read 0 while in reset.
      assign bus.rd_data[gi*DATA_W +: DATA_W] =
          (!reset_n || (w_addr == ADDR_W'(REG_ZERO))) ? '0 :
          w_fwd             ? bus.wr_data   :
          r_valid[w_addr]   ? r_mem[w_addr] : '0;
    end
  endgenerate

  // v0 debug tap reflects committed state only, never the bypass path.
  assign bus.register_v0 = (reset_n && r_valid[ADDR_W'(REG_V0)]) ?
                           r_mem[ADDR_W'(REG_V0)] : '0;

  mips_cpu_scoreboard #(
    .ADDR_W (ADDR_W),
    .N_RD   (N_RD),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_pend_set   (bus.pend_set),
    .i_pend_addr  (bus.pend_addr),
    .i_wr_en      (bus.wr_en),
    .i_wr_addr    (bus.wr_addr),
    .i_rd_addr    (bus.rd_addr),
    .o_rd_busy    (bus.rd_busy),
    .o_pend_count (bus.pend_count)
  );

endmodule

// File: tb/tb_mips_cpu_regfile_sb.sv
// Testbench: tb_mips_cpu_regfile_sb
// Drives identical stimulus into a BYPASS=1 and a BYPASS=0 instance and
// compares both against an array-based architectural model.
module tb_mips_cpu_regfile_sb;
  import mips_cpu_regfile_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic clk;
  logic rst_n;

  mips_cpu_regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR)) bus_b1 ();
  mips_cpu_regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR)) bus_b0 ();

  mips_cpu_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .BYPASS(1)) dut_b1 (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus_b1.slave)
  );

  mips_cpu_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .BYPASS(0)) dut_b0 (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus_b0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // architectural model
  reg_data_t m_mem   [32];
  bit        m_valid [32];
  bit        m_pend  [32];

  // inputs currently applied
  bit        cur_we;
  int        cur_wa;
  reg_data_t cur_wd;
  bit        cur_ps;
  int        cur_pa;
  int        cur_ra [NR];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic reg_data_t exp_data(input bit byp, input int a);
    if (!rst_n || a == 0) return '0;
    if (byp && cur_we && cur_wa == a) return cur_wd;
    return m_valid[a] ? m_mem[a] : '0;
  endfunction

  function automatic bit exp_busy(input bit byp, input int a);
    if (!rst_n || a == 0) return 1'b0;
    if (byp && cur_we && cur_wa == a) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  function automatic reg_data_t exp_v0();
    return (rst_n && m_valid[REG_V0]) ? m_mem[REG_V0] : '0;
  endfunction

  task automatic drive(input bit we, input int wa, input reg_data_t wd,
                       input bit ps, input int pa, input int ra0, input int ra1);
    cur_we = we; cur_wa = wa; cur_wd = wd; cur_ps = ps; cur_pa = pa;
    cur_ra[0] = ra0; cur_ra[1] = ra1;
    bus_b1.wr_en = we;   bus_b0.wr_en = we;
    bus_b1.wr_addr = AW'(wa); bus_b0.wr_addr = AW'(wa);
    bus_b1.wr_data = wd; bus_b0.wr_data = wd;
    bus_b1.pend_set = ps; bus_b0.pend_set = ps;
    bus_b1.pend_addr = AW'(pa); bus_b0.pend_addr = AW'(pa);
    bus_b1.rd_addr = {AW'(ra1), AW'(ra0)};
    bus_b0.rd_addr = {AW'(ra1), AW'(ra0)};
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("%s b1 rd_data[%0d] r%0d", tag, k, cur_ra[k]),
          64'(bus_b1.rd_data[k*DW +: DW]), 64'(exp_data(1'b1, cur_ra[k])));
      chk($sformatf("%s b0 rd_data[%0d] r%0d", tag, k, cur_ra[k]),
          64'(bus_b0.rd_data[k*DW +: DW]), 64'(exp_data(1'b0, cur_ra[k])));
      chk($sformatf("%s b1 rd_busy[%0d] r%0d", tag, k, cur_ra[k]),
          64'(bus_b1.rd_busy[k]), 64'(exp_busy(1'b1, cur_ra[k])));
      chk($sformatf("%s b0 rd_busy[%0d] r%0d", tag, k, cur_ra[k]),
          64'(bus_b0.rd_busy[k]), 64'(exp_busy(1'b0, cur_ra[k])));
    end
    chk({tag, " b1 pend_count"}, 64'(bus_b1.pend_count), 64'(m_count()));
    chk({tag, " b0 pend_count"}, 64'(bus_b0.pend_count), 64'(m_count()));
    chk({tag, " b1 register_v0"}, 64'(bus_b1.register_v0), 64'(exp_v0()));
    chk({tag, " b0 register_v0"}, 64'(bus_b0.register_v0), 64'(exp_v0()));
  endtask

  // One clock: apply inputs after the falling edge, check combinational
  // outputs against pre-edge model state, then advance the model at the edge.
  task automatic step(input string tag, input bit we, input int wa, input reg_data_t wd,
                      input bit ps, input int pa, input int ra0, input int ra1);
    drive(we, wa, wd, ps, pa, ra0, ra1);
    #1;
    check_all(tag);
    $display("txn %s we=%0d wa=%0d wd=%h ps=%0d pa=%0d ra=%0d,%0d cnt=%0d",
             tag, we, wa, wd, ps, pa, ra0, ra1, m_count());
    @(posedge clk);
    if (rst_n) begin
      if (we && wa != 0) begin
        m_mem[wa] = wd; m_valid[wa] = 1'b1; m_pend[wa] = 1'b0;
      end
      if (ps && pa != 0) m_pend[pa] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_pend[i]  = 1'b0;
    end
  endtask

  // Reset asserted between edges with a write and a load in flight.
  task automatic mid_reset(input string tag);
    drive(1'b1, $urandom_range(1, 31), $urandom, 1'b1, $urandom_range(1, 31),
          $urandom_range(1, 31), $urandom_range(1, 31));
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    chk({tag, " pend_count zero"}, 64'(bus_b1.pend_count), 64'd0);
    $display("txn %s async reset asserted mid-cycle", tag);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int rnd_addr();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                       : int'($urandom_range(0, 7));
  endfunction

  initial begin
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    drive(1'b0, 0, '0, 1'b0, 0, 0, 0);

    // in reset: writes and loads ignored, everything reads 0
    @(negedge clk);
    step("rst0", 1'b1, 2, 32'h11111111, 1'b1, 3, 2, 3);
    step("rst1", 1'b1, 5, 32'h22222222, 1'b1, 5, 5, 1);
    rst_n = 1'b1;

    // after release every register reads 0, nothing busy
    for (int a = 1; a < 32; a++)
      step("post_rst", 1'b0, 0, '0, 1'b0, 0, a, 32 - a);

    // v0 and hardwired zero
    step("wr_r2", 1'b1, 2, 32'hDEADBEEF, 1'b0, 0, 2, 0);
    step("wr_r0", 1'b1, 0, 32'h00001234, 1'b0, 0, 0, 2);
    step("rd_r0_r2", 1'b0, 0, '0, 1'b0, 0, 0, 2);

    // same-cycle bypass: b1 sees new data, b0 sees old (0)
    step("byp_r5", 1'b1, 5, 32'hA5A5A5A5, 1'b0, 0, 5, 5);
    step("byp_r5b", 1'b1, 5, 32'h5A5A5A5A, 1'b0, 0, 5, 4);
    step("rd_r5", 1'b0, 0, '0, 1'b0, 0, 5, 5);

    // set wins over same-cycle write
    step("ps_r8", 1'b0, 0, '0, 1'b1, 8, 8, 0);
    step("wr_ps_r8", 1'b1, 8, 32'hCAFEF00D, 1'b1, 8, 8, 0);
    step("chk_r8", 1'b0, 0, '0, 1'b0, 0, 8, 8);
    step("wr_r8", 1'b1, 8, 32'h0BADF00D, 1'b0, 0, 8, 1);

    // count 1,2,2,1
    step("ps_r3", 1'b0, 0, '0, 1'b1, 3, 3, 4);
    step("ps_r4", 1'b0, 0, '0, 1'b1, 4, 3, 4);
    step("ps_r3b", 1'b0, 0, '0, 1'b1, 3, 3, 4);
    step("wr_r3", 1'b1, 3, 32'h33333333, 1'b0, 0, 3, 4);
    step("chk_r3", 1'b0, 0, '0, 1'b1, 0, 3, 4);

    mid_reset("mid_rst0");
    step("after_rst", 1'b0, 0, '0, 1'b0, 0, 2, 4);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (i == 150 || i == 320) mid_reset($sformatf("rand_rst%0d", i));
      step($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), rnd_addr(), $urandom,
           1'($urandom_range(0, 1)), rnd_addr(), rnd_addr(), rnd_addr());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
